// File: rtl/pc_branch_ctrl.sv
// PC register with fetch-time branch prediction (2-bit saturating BHT),
// EX-stage branch resolution with one-cycle flush/redirect, HLT freeze and mispredict counting.
module pc_branch_ctrl #(
    parameter int               WIDTH     = 16,
    parameter int               OFF_W     = 9,
    parameter int               BHT_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_br,
    input  logic             if_hlt,
    input  logic [OFF_W-1:0] if_imm,
    input  logic             ex_br,
    input  logic             ex_br_reg,
    input  logic [2:0]       ex_ccc,
    input  logic [2:0]       ex_flags,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [OFF_W-1:0] ex_imm,
    input  logic [WIDTH-1:0] ex_rs,
    input  logic             ex_pred,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus2,
    output logic             if_pred,
    output logic             flush,
    output logic             halted,
    output logic [15:0]      mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [0:0] {RUN, HALTED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [1:0]       bht_q [BHT_DEPTH];
    logic [15:0]      cnt_q;

    logic             actual;
    logic             mispredict;
    logic [WIDTH-1:0] fetch_target;
    logic [WIDTH-1:0] ex_target;
    logic [WIDTH-1:0] redirect_pc;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ctr_cur, ctr_upd;

    function automatic logic [WIDTH-1:0] rel_target(input logic [WIDTH-1:0] base,
                                                    input logic [OFF_W-1:0] imm);
        logic [WIDTH-1:0] off;
        off = {{(WIDTH-OFF_W){imm[OFF_W-1]}}, imm};
        return base + WIDTH'(2) + (off << 1);
    endfunction

    // flags are {Z,V,N}
    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] flags);
        logic z, v, n;
        z = flags[2];
        v = flags[1];
        n = flags[0];
        case (ccc)
            3'b000:  return !z;
            3'b001:  return z;
            3'b010:  return !z && !n;
            3'b011:  return n;
            3'b100:  return z || !n;
            3'b101:  return n || z;
            3'b110:  return v;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        actual       = cond_met(ex_ccc, ex_flags);
        mispredict   = ex_br && (actual != ex_pred);
        flush        = mispredict && !rst;
        if_pred      = if_br && bht_q[pc_q[IDX_W:1]][1];
        fetch_target = rel_target(pc_q, if_imm);
        ex_target    = ex_br_reg ? ex_rs : rel_target(ex_pc, ex_imm);
        redirect_pc  = actual ? ex_target : ex_pc + WIDTH'(2);
        ex_idx       = ex_pc[IDX_W:1];
        ctr_cur      = bht_q[ex_idx];
        if (actual) ctr_upd = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'd1;
        else        ctr_upd = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'd1;
    end

    // Entering HALTED keeps pc on the HLT itself rather than stepping past it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q + WIDTH'(2);
        case (state_q)
            RUN: begin
                if (flush) begin
                    pc_d = redirect_pc;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (if_hlt) begin
                    state_d = HALTED;
                    pc_d    = pc_q;
                end else if (if_pred) begin
                    pc_d = fetch_target;
                end
            end
            HALTED: begin
                if (flush) begin
                    state_d = RUN;
                    pc_d    = redirect_pc;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = RUN;
                pc_d    = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (flush && cnt_q != '1) cnt_q <= cnt_q + 16'd1;
            if (ex_br && !ex_br_reg) bht_q[ex_idx] <= ctr_upd;
        end
    end

    assign pc          = pc_q;
    assign pc_plus2    = pc_q + WIDTH'(2);
    assign halted      = (state_q == HALTED);
    assign mispred_cnt = cnt_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed test-plan steps followed by
// random traffic, all checked against an integer reference model.
module tb_pc_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, if_br, if_hlt, ex_br, ex_br_reg, ex_pred;
    logic [8:0]  if_imm, ex_imm;
    logic [2:0]  ex_ccc, ex_flags;
    logic [15:0] ex_pc, ex_rs;
    logic [15:0] pc, pc_plus2, mispred_cnt;
    logic        if_pred, flush, halted;

    int checks = 0;
    int errors = 0;

    int unsigned m_pc;
    int unsigned m_cnt;
    bit          m_halt;
    int          m_bht [16];

    always #5 clk = ~clk;

    pc_branch_ctrl #(.WIDTH(16), .OFF_W(9), .BHT_DEPTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .if_br(if_br), .if_hlt(if_hlt),
        .if_imm(if_imm), .ex_br(ex_br), .ex_br_reg(ex_br_reg), .ex_ccc(ex_ccc),
        .ex_flags(ex_flags), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs(ex_rs),
        .ex_pred(ex_pred), .pc(pc), .pc_plus2(pc_plus2), .if_pred(if_pred),
        .flush(flush), .halted(halted), .mispred_cnt(mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ref(input int ccc, input logic [2:0] fl);
        bit z, v, n;
        z = fl[2]; v = fl[1]; n = fl[0];
        case (ccc)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return n || z;
            6: return v;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned rel_ref(input int unsigned base, input logic [8:0] imm);
        int s;
        s = int'(imm);
        if (s >= 256) s -= 512;
        return (int'(base) + 2 + 2 * s) & 32'hFFFF;
    endfunction

    function automatic int idx_ref(input int unsigned p);
        return (p >> 1) % 16;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_halt = 0;
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
    endtask

    // Check current outputs against the model, then advance one clock.
    task automatic cycle();
        bit          act, e_flush, e_pred;
        int unsigned n_pc, tgt;
        bit          n_halt;
        int          k;
        @(negedge clk);
        act     = cond_ref(int'(ex_ccc), ex_flags);
        e_flush = !rst && ex_br && (act != ex_pred);
        e_pred  = if_br && (m_bht[idx_ref(m_pc)] >= 2);
        chk("pc", {16'b0, pc}, m_pc);
        chk("pc_plus2", {16'b0, pc_plus2}, (m_pc + 2) % 65536);
        chk("halted", {31'b0, halted}, {31'b0, m_halt});
        chk("mispred_cnt", {16'b0, mispred_cnt}, m_cnt);
        chk("flush", {31'b0, flush}, {31'b0, e_flush});
        chk("if_pred", {31'b0, if_pred}, {31'b0, e_pred});
        n_pc = m_pc; n_halt = m_halt;
        if (e_flush) begin
            tgt    = ex_br_reg ? int'(ex_rs) : rel_ref(ex_pc, ex_imm);
            n_pc   = act ? tgt : (int'(ex_pc) + 2) % 65536;
            n_halt = 0;
        end else if (m_halt || stall) begin
            n_pc = m_pc;
        end else if (if_hlt) begin
            n_halt = 1;
        end else if (e_pred) begin
            n_pc = rel_ref(m_pc, if_imm);
        end else begin
            n_pc = (m_pc + 2) % 65536;
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (ex_br && !ex_br_reg) begin
                k = idx_ref(ex_pc);
                if (act && m_bht[k] < 3) m_bht[k]++;
                if (!act && m_bht[k] > 0) m_bht[k]--;
            end
            if (e_flush && m_cnt < 65535) m_cnt++;
            m_pc = n_pc; m_halt = n_halt;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; stall = 0; if_br = 0; if_hlt = 0; if_imm = '0;
        ex_br = 0; ex_br_reg = 0; ex_ccc = '0; ex_flags = '0;
        ex_pc = '0; ex_imm = '0; ex_rs = '0; ex_pred = 0;
    endtask

    task automatic br_reg_to(input logic [15:0] target);
        ex_br = 1; ex_br_reg = 1; ex_ccc = 3'b111; ex_rs = target; ex_pred = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        chk("reset_halted", {31'b0, halted}, 32'd0);
        chk("reset_cnt", {16'b0, mispred_cnt}, 32'd0);

        for (int k = 0; k < 4; k++) begin
            chk("pc_seq", {16'b0, pc}, 32'(2 * k));
            cycle();
        end

        // EQ taken, predicted not-taken
        ex_br = 1; ex_ccc = 3'b001; ex_flags = 3'b100; ex_pc = 16'h0010;
        ex_imm = 9'h002; ex_pred = 0;
        #1 chk("mp_flush", {31'b0, flush}, 32'd1);
        cycle();
        chk("mp_pc", {16'b0, pc}, 32'h16);
        chk("mp_cnt", {16'b0, mispred_cnt}, 32'd1);
        idle();

        // train index of 0x0020 to strongly taken
        ex_br = 1; ex_pc = 16'h0020; ex_imm = 9'h1FE; ex_ccc = 3'b111; ex_pred = 1;
        cycle();
        cycle();
        idle();
        br_reg_to(16'h0020);
        cycle();
        chk("train_pc", {16'b0, pc}, 32'h20);
        idle();
        if_br = 1; if_imm = 9'h1FE;
        #1 chk("bht_pred", {31'b0, if_pred}, 32'd1);
        cycle();
        chk("bht_target", {16'b0, pc}, 32'h1E);
        idle();
        ex_br = 1; ex_pc = 16'h0020; ex_imm = 9'h1FE; ex_ccc = 3'b000;
        ex_flags = 3'b100; ex_pred = 1;
        #1 chk("nt_flush", {31'b0, flush}, 32'd1);
        cycle();
        chk("nt_pc", {16'b0, pc}, 32'h22);
        idle();

        // BR redirect overrides stall
        br_reg_to(16'h00FF); stall = 1;
        #1 chk("br_flush", {31'b0, flush}, 32'd1);
        cycle();
        chk("br_pc", {16'b0, pc}, 32'hFF);
        idle();

        // HLT freeze, released by flush
        br_reg_to(16'h0030);
        cycle();
        idle();
        if_hlt = 1;
        cycle();
        idle();
        chk("hlt_on", {31'b0, halted}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("hlt_pc", {16'b0, pc}, 32'h30);
        end
        br_reg_to(16'h0040);
        cycle();
        idle();
        chk("hlt_off", {31'b0, halted}, 32'd0);
        chk("hlt_redir", {16'b0, pc}, 32'h40);

        // flush beats a simultaneous HLT
        if_hlt = 1;
        br_reg_to(16'h0050);
        cycle();
        idle();
        chk("hf_halted", {31'b0, halted}, 32'd0);
        chk("hf_pc", {16'b0, pc}, 32'h50);

        // reset mid-run masks flush
        rst = 1;
        br_reg_to(16'h0070);
        #1 chk("rst_flush", {31'b0, flush}, 32'd0);
        cycle();
        idle();
        chk("rst_pc", {16'b0, pc}, 32'd0);
        chk("rst_cnt", {16'b0, mispred_cnt}, 32'd0);

        for (int k = 0; k < 500; k++) begin
            rst       = ($urandom_range(0, 59) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            if_br     = ($urandom_range(0, 2) == 0);
            if_hlt    = ($urandom_range(0, 24) == 0);
            if_imm    = 9'($urandom);
            ex_br     = ($urandom_range(0, 2) == 0);
            ex_br_reg = ($urandom_range(0, 3) == 0);
            ex_ccc    = 3'($urandom);
            ex_flags  = 3'($urandom);
            ex_pc     = 16'($urandom);
            ex_imm    = 9'($urandom);
            ex_rs     = 16'($urandom);
            ex_pred   = 1'($urandom);
            cycle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Parametrised successor to the single-cycle PC control block for the 5-stage pipeline. It owns the PC register and predicts PC-relative branches at fetch with a table of 2-bit saturating counters. Branches (B and BR) are resolved from EX-stage inputs, and a mispredict raises a one-cycle flush and redirects the PC. It also implements HLT freeze, stall hold, and a saturating mispredict counter.

## Interface
- WIDTH, 16, PC/data width
- OFF_W, 9, branch immediate width (signed word offset)
- BHT_DEPTH, 16, predictor entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold PC (hazard unit)
- if_br  in  1  fetched instruction is B (PC-relative)
- if_hlt  in  1  fetched instruction is HLT
- if_imm  in  OFF_W  fetched B immediate
- ex_br  in  1  valid branch resolving in EX this cycle
- ex_br_reg  in  1  EX branch is BR (target = ex_rs)
- ex_ccc  in  3  condition code
- ex_flags  in  3  {Z,V,N}
- ex_pc  in  WIDTH  PC of the EX branch
- ex_imm  in  OFF_W  EX branch immediate
- ex_rs  in  WIDTH  register target for BR
- ex_pred  in  1  prediction carried down the pipe for the EX branch
- pc  out  WIDTH  current fetch PC
- pc_plus2  out  WIDTH  pc + 2
- if_pred  out  1  fetch-side predict-taken
- flush  out  1  kill IF/ID and ID/EX contents
- halted  out  1  PC frozen by HLT
- mispred_cnt  out  16  saturating mispredict count

## Operation
- Conditions on ccc: 000 NE (!Z); 001 EQ (Z); 010 GT (!Z&!N); 011 LT (N); 100 GTE (Z | !N); 101 LTE (N|Z); 110 OV (V); 111 always.
- PC-relative target: ex_pc + 2 + (sext(ex_imm) << 1). Arithmetic is modulo 2^WIDTH and wraps silently. The fetch-side target uses the same formula with pc and if_imm.
- BHT index: pc[log2(BHT_DEPTH):1]. Counters reset to 01 (weakly not-taken). Prediction is counter[1].
- if_pred = if_br & counter[index(pc)]. BR is always predicted not-taken.
- Resolve (ex_br=1): actual = condition(ex_ccc, ex_flags).
  - Mispredict when actual != ex_pred. For a taken B, an equal prediction is correct.
  - On mispredict: flush=1. Next pc = actual ? target : ex_pc+2, where target is ex_rs for BR.
  - For B only, the counter at index(ex_pc) increments if taken and decrements if not taken, saturating at 00 and 11.
- Next-PC priority: rst → RESET_PC; redirect (flush) → corrected PC, overriding stall and halt; halted or stall → hold; if_pred → fetch target; else pc+2.
- State machine:
  - RUN → HALTED when if_hlt & !stall & !flush.
  - HALTED holds pc (pc stays at the HLT address) with halted=1.
  - A flush in HALTED returns to RUN and redirects, because a wrong-path HLT must be cancelled.
  - rst → RUN.
- mispred_cnt increments once per mispredict and saturates at 16'hFFFF.
- Reset values: pc=RESET_PC, halted=0, mispred_cnt=0, all counters=01. flush and if_pred follow their inputs combinationally.

## Timing
- pc, halted, BHT, and mispred_cnt are registered on the rising clk.
- flush and if_pred are combinational in the same cycle as their inputs.
- Redirect latency is 1 cycle: the cycle after flush, pc equals the corrected PC.
- Fetch-predicted taken: the cycle after if_pred=1 (stall=0), pc equals the fetch target.
- A BHT read and write to the same index in the same cycle returns the old counter. The new value is visible the next cycle.
- Simultaneous flush and if_hlt: flush wins, the state stays RUN, and the fetched HLT is discarded.
- Simultaneous flush and stall: the redirect is taken.
- rst asserted mid-operation:
  - Next cycle: all state is at reset values.
  - flush is forced to 0 while rst=1.
  - Counters are not updated while rst=1.

## Test plan
- Reset, then 4 cycles with no inputs → pc = 0000, 0002, 0004, 0006; halted=0; mispred_cnt=0.
- ex_br=1, ex_ccc=001, ex_flags=100, ex_pc=0010, ex_imm=002, ex_pred=0 → flush=1 that cycle, next pc=0016, mispred_cnt=1.
- Train a B at pc=0020 with imm=1FE, resolving taken twice → counter=11. Next fetch with pc=0020, if_br=1 → if_pred=1, next pc=001E. Then resolve not-taken with ex_pred=1 → flush, pc=0022.
- BR with ex_ccc=111, ex_rs=00FF, ex_pred=0, stall=1 → flush=1, next pc=00FF despite stall. BHT is unchanged.
- if_hlt=1 at pc=0030 → halted=1, pc holds 0030 for 10 cycles. A later flush to 0040 → halted=0, pc=0040.
- if_hlt=1 with a simultaneous mispredict to 0050 → halted stays 0, pc=0050. Then pulse rst → pc=0000, mispred_cnt=0.
